// File: rtl/mem_bus_arbiter.sv
// N-master byte-bus arbiter with RAM/IO decode. Grant and access are issued in the same cycle; read data returns one cycle later.
// Backpressure: a master that loses arbitration (or any non-debug master during debug) holds m_req_in until it is granted.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IO_SEL_WIDTH   = 3,
  parameter int DBG_MASTER     = NUM_MASTERS - 1
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              dbg_active_in,
  input  logic [NUM_MASTERS-1:0]            m_req_in,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a_in,
  input  logic [NUM_MASTERS-1:0]            m_wr_in,
  input  logic [NUM_MASTERS*8-1:0]          m_dout_in,
  output logic [NUM_MASTERS-1:0]            m_gnt_out,
  output logic [NUM_MASTERS-1:0]            m_rvalid_out,
  output logic [7:0]                        m_din_out,
  output logic                              ram_en_out,
  output logic                              ram_r_nw_out,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_a_out,
  output logic [7:0]                        ram_d_out,
  input  logic [7:0]                        ram_d_in,
  output logic                              io_en_out,
  output logic [IO_SEL_WIDTH-1:0]           io_sel_out,
  output logic                              io_wr_out,
  output logic [7:0]                        io_d_out,
  input  logic [7:0]                        io_d_in
);

  localparam int PTR_W = $clog2(NUM_MASTERS);

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rd_src;
  logic                  rd_pend;
  logic                  rd_io;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic [ADDR_WIDTH-1:0] sel_a;
  logic                  sel_wr;
  logic [7:0]            sel_d;
  logic                  sel_io;
  logic                  unused_addr_bits;

  // Winner is the requester at the smallest rotational distance from rr_ptr.
  always_comb begin : arbitrate
    int best_d;
    int d;
    gnt_any = 1'b0;
    gnt_idx = '0;
    best_d  = NUM_MASTERS;
    d       = 0;
    if (rst_n_in) begin
      if (dbg_active_in) begin
        gnt_any = m_req_in[DBG_MASTER];
        gnt_idx = PTR_W'(DBG_MASTER);
      end else begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          d = i - int'(rr_ptr);
          if (d < 0) d = d + NUM_MASTERS;
          if (m_req_in[i] && d < best_d) begin
            best_d  = d;
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_wr    = 1'b0;
    sel_d     = '0;
    m_gnt_out = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        sel_a  = m_a_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wr = m_wr_in[i];
        sel_d  = m_dout_in[i*8 +: 8];
        m_gnt_out[i] = gnt_any;
      end
    end
  end

  assign sel_io           = (sel_a[RAM_ADDR_WIDTH -: 2] == 2'b11);
  assign unused_addr_bits = ^sel_a[ADDR_WIDTH-1:RAM_ADDR_WIDTH+1];

  always_comb begin
    ram_en_out   = 1'b0;
    ram_r_nw_out = 1'b1;
    ram_a_out    = '0;
    ram_d_out    = '0;
    io_en_out    = 1'b0;
    io_sel_out   = '0;
    io_wr_out    = 1'b0;
    io_d_out     = '0;
    if (gnt_any) begin
      if (sel_io) begin
        io_en_out  = 1'b1;
        io_sel_out = sel_a[IO_SEL_WIDTH-1:0];
        io_wr_out  = sel_wr;
        io_d_out   = sel_wr ? sel_d : 8'h00;
      end else begin
        ram_en_out   = 1'b1;
        ram_r_nw_out = ~sel_wr;
        ram_a_out    = sel_a[RAM_ADDR_WIDTH-1:0];
        ram_d_out    = sel_wr ? sel_d : 8'h00;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rr_ptr  <= '0;
      rd_pend <= 1'b0;
      rd_src  <= '0;
      rd_io   <= 1'b0;
    end else begin
      rd_pend <= gnt_any && !sel_wr;
      if (gnt_any && !sel_wr) begin
        rd_src <= gnt_idx;
        rd_io  <= sel_io;
      end
      if (gnt_any && !dbg_active_in)
        rr_ptr <= (gnt_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // The tag captured at issue steers the return mux, so a newer access in the same cycle cannot redirect it.
  always_comb begin
    m_rvalid_out = '0;
    m_din_out    = '0;
    if (rd_pend && rst_n_in) begin
      for (int i = 0; i < NUM_MASTERS; i++)
        if (rd_src == PTR_W'(i)) m_rvalid_out[i] = 1'b1;
      m_din_out = rd_io ? io_d_in : ram_d_in;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter, checked against a cycle-level reference model.
module tb_mem_bus_arbiter;
  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int RW  = 17;
  localparam int SW  = 3;
  localparam int DBG = N - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dbg;
  logic [N-1:0]    req;
  logic [N*AW-1:0] ma;
  logic [N-1:0]    mwr;
  logic [N*8-1:0]  mdout;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [7:0]      din;
  logic            ram_en;
  logic            ram_r_nw;
  logic [RW-1:0]   ram_a;
  logic [7:0]      ram_d;
  logic [7:0]      ram_q;
  logic            io_en;
  logic [SW-1:0]   io_sel;
  logic            io_wr;
  logic [7:0]      io_d;
  logic [7:0]      io_q;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RW),
                    .IO_SEL_WIDTH(SW), .DBG_MASTER(DBG)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .dbg_active_in(dbg),
    .m_req_in(req), .m_a_in(ma), .m_wr_in(mwr), .m_dout_in(mdout),
    .m_gnt_out(gnt), .m_rvalid_out(rvalid), .m_din_out(din),
    .ram_en_out(ram_en), .ram_r_nw_out(ram_r_nw), .ram_a_out(ram_a),
    .ram_d_out(ram_d), .ram_d_in(ram_q),
    .io_en_out(io_en), .io_sel_out(io_sel), .io_wr_out(io_wr),
    .io_d_out(io_d), .io_d_in(io_q)
  );

  // Reference model state: round-robin start point and the read awaiting its data.
  int          rr;
  bit          pend;
  int          psrc;
  bit          pio;
  int          cur_g;
  bit          cur_io;
  int          n_chk, n_pass, n_fail;
  logic [N-1:0] last_gnt, last_rv;

  function automatic int pick();
    if (!rst_n) return -1;
    if (dbg) return req[DBG] ? DBG : -1;
    for (int k = 0; k < N; k++)
      if (req[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] a;
    bit          w;
    logic [7:0]  d;
    cur_g  = pick();
    a      = (cur_g >= 0) ? ma[cur_g*AW +: AW] : 32'h0;
    w      = (cur_g >= 0) ? mwr[cur_g] : 1'b0;
    d      = (cur_g >= 0) ? mdout[cur_g*8 +: 8] : 8'h00;
    cur_io = (cur_g >= 0) && (a[RW:RW-1] == 2'b11);
    chk("gnt", 32'(gnt), (cur_g >= 0) ? (32'd1 << cur_g) : 32'd0);
    chk("rvalid", 32'(rvalid), (pend && rst_n) ? (32'd1 << psrc) : 32'd0);
    chk("din", 32'(din), (pend && rst_n) ? 32'(pio ? io_q : ram_q) : 32'd0);
    chk("ram_en", 32'(ram_en), 32'((cur_g >= 0) && !cur_io));
    chk("ram_r_nw", 32'(ram_r_nw), 32'(!((cur_g >= 0) && !cur_io && w)));
    chk("ram_a", 32'(ram_a), ((cur_g >= 0) && !cur_io) ? (a & 32'h1FFFF) : 32'd0);
    chk("ram_d", 32'(ram_d), ((cur_g >= 0) && !cur_io && w) ? 32'(d) : 32'd0);
    chk("io_en", 32'(io_en), 32'(cur_io));
    chk("io_sel", 32'(io_sel), cur_io ? (a & 32'h7) : 32'd0);
    chk("io_wr", 32'(io_wr), 32'(cur_io && w));
    chk("io_d", 32'(io_d), (cur_io && w) ? 32'(d) : 32'd0);
    last_gnt = gnt;
    last_rv  = rvalid;
  endtask

  task automatic update_model();
    if (!rst_n) begin
      rr   = 0;
      pend = 1'b0;
    end else begin
      if (cur_g >= 0 && !dbg) rr = (cur_g + 1) % N;
      pend = (cur_g >= 0) && !mwr[cur_g];
      if (pend) begin
        psrc = cur_g;
        pio  = cur_io;
      end
    end
  endtask

  // Inputs are applied 1 time unit after posedge; outputs are checked at negedge.
  task automatic run_cycle();
    ram_q = 8'($urandom);
    io_q  = 8'($urandom);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_m(input int i, input bit r, input logic [31:0] addr,
                       input bit w, input logic [7:0] d);
    req[i]           = r;
    ma[i*AW +: AW]   = addr;
    mwr[i]           = w;
    mdout[i*8 +: 8]  = d;
  endtask

  task automatic all_off();
    for (int i = 0; i < N; i++) set_m(i, 1'b0, 32'h0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] ra;
    n_chk = 0; n_pass = 0; n_fail = 0;
    rr = 0; pend = 1'b0; psrc = 0; pio = 1'b0; cur_g = -1; cur_io = 1'b0;
    rst_n = 1'b0; dbg = 1'b0;
    req = '0; ma = '0; mwr = '0; mdout = '0; ram_q = '0; io_q = '0;
    #1;

    // Reset held with every master requesting
    for (int i = 0; i < N; i++) set_m(i, 1'b1, 32'h100 + 32'(i), 1'b0, 8'h00);
    run_cycle();
    run_cycle();
    chk("reset_gnt", 32'(last_gnt), 32'd0);
    rst_n = 1'b1;
    run_cycle();
    chk("first_gnt", 32'(last_gnt), 32'b001);

    // Continuous round-robin reads
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      chk("rr_seq", 32'(last_gnt), 32'd1 << ((k + 1) % N));
    end
    run_cycle();

    // Decode: IO read then RAM read from master 1
    all_off();
    set_m(1, 1'b1, 32'h0003_0004, 1'b0, 8'h00);
    run_cycle();
    set_m(1, 1'b1, 32'h0000_1234, 1'b0, 8'h00);
    run_cycle();
    all_off();
    run_cycle();
    chk("decode_rv", 32'(last_rv), 32'b010);

    // Debug ownership
    set_m(0, 1'b1, 32'h0000_0100, 1'b0, 8'h00);
    run_cycle();
    dbg = 1'b1;
    set_m(2, 1'b1, 32'h0000_0200, 1'b0, 8'h00);
    run_cycle();
    chk("dbg_gnt", 32'(last_gnt), 32'b100);
    chk("dbg_old_rv", 32'(last_rv), 32'b001);
    run_cycle();
    chk("dbg_hold", 32'(last_gnt), 32'b100);
    dbg = 1'b0;
    set_m(2, 1'b0, 32'h0, 1'b0, 8'h00);
    run_cycle();
    chk("dbg_drop_gnt", 32'(last_gnt), 32'b001);

    // Writes to RAM and IO
    all_off();
    set_m(0, 1'b1, 32'h0000_0010, 1'b1, 8'hA5);
    run_cycle();
    set_m(0, 1'b1, 32'h0003_0000, 1'b1, 8'h5A);
    run_cycle();
    all_off();
    run_cycle();
    chk("write_no_rv", 32'(last_rv), 32'd0);

    // Reset arriving while a read is pending
    set_m(1, 1'b1, 32'h0000_0200, 1'b0, 8'h00);
    run_cycle();
    all_off();
    rst_n = 1'b0;
    run_cycle();
    chk("rst_drop_rv", 32'(last_rv), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_m(i, 1'b1, 32'h300 + 32'(i), 1'b0, 8'h00);
    run_cycle();
    chk("post_rst_gnt", 32'(last_gnt), 32'b001);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      dbg   = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        ra = $urandom;
        if ($urandom_range(0, 1) == 1) ra[RW:RW-1] = 2'b11;
        set_m(i, 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
